// File: rtl/zbt_responder.sv
// zbt_responder: plays the RAM side of a pipelined ZBT SRAM (two-cycle latency).
//
// Commands {we, addr} are taken on every enabled edge (ram_cen_b=0, reset=0).
// They move stage 1 -> stage 2 on the next enabled edge and retire on the one after.
// A write captures ram_data_in as it retires.
// A read drives ram_data_out/ram_data_oe while it sits in stage 2.
// Reads see every earlier-issued write, including writes that are still in flight.
//
// Parameters:
//   ADDR_W  array depth is 2^ADDR_W words; ram_address[18:ADDR_W] is ignored
//   DATA_W  data word width
// Ports:
//   clk, reset            clock, synchronous active-high reset (array contents kept)
//   ram_cen_b             active-low enable; high freezes everything
//   ram_we_b, ram_address command write-enable (active low) and address
//   ram_data_in           write data, sampled at the write's retiring edge
//   ram_data_out, ram_data_oe  registered read data and bus-ownership flag
//   rd_count, wr_count    saturating statistics counters
// Optional feature: define ZBT_RESP_STATS_EN to build the counters. Without it they read 0.

module zbt_responder #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 36
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ram_cen_b,
    input  logic              ram_we_b,
    input  logic [18:0]       ram_address,
    input  logic [DATA_W-1:0] ram_data_in,
    output logic [DATA_W-1:0] ram_data_out,
    output logic              ram_data_oe,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
);

    logic              en;
    logic [ADDR_W-1:0] cmd_addr;
    logic              unused_addr_hi;

    assign en             = ~ram_cen_b & ~reset;
    assign cmd_addr       = ram_address[ADDR_W-1:0];
    assign unused_addr_hi = ^ram_address[18:ADDR_W];

    logic              s1_valid_q, s1_we_q, s1_fwd_q;
    logic [ADDR_W-1:0] s1_addr_q;
    logic [DATA_W-1:0] s1_fwd_data_q;
    logic              s2_valid_q, s2_we_q;
    logic [ADDR_W-1:0] s2_addr_q;

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] mem_rdata_q;

    logic              s2_wr, s2_hit_cmd, s2_hit_s1, s1_rd;
    logic [DATA_W-1:0] rd_data_d;

    assign s2_wr      = s2_valid_q & s2_we_q;
    // The write retiring now was issued two edges before the incoming command.
    // The array read taken at this edge misses that write, so its data is latched here.
    assign s2_hit_cmd = s2_wr && (s2_addr_q == cmd_addr);
    // The write retiring now was issued one edge before the read in stage 1.
    // It is the newest source, so it takes priority.
    assign s2_hit_s1  = s2_wr && (s2_addr_q == s1_addr_q);
    assign s1_rd      = s1_valid_q & ~s1_we_q;

    always_comb begin
        rd_data_d = mem_rdata_q;
        if (s2_hit_s1) begin
            rd_data_d = ram_data_in;
        end else if (s1_fwd_q) begin
            rd_data_d = s1_fwd_data_q;
        end
    end

    // Plain synchronous-read array. Reset never touches contents.
    always_ff @(posedge clk) begin
        if (en) begin
            if (s2_wr) begin
                mem[s2_addr_q] <= ram_data_in;
            end
            mem_rdata_q <= mem[cmd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q    <= 1'b0;
            s1_we_q       <= 1'b0;
            s1_addr_q     <= '0;
            s1_fwd_q      <= 1'b0;
            s1_fwd_data_q <= '0;
            s2_valid_q    <= 1'b0;
            s2_we_q       <= 1'b0;
            s2_addr_q     <= '0;
            ram_data_oe   <= 1'b0;
            ram_data_out  <= '0;
        end else if (!ram_cen_b) begin
            s1_valid_q    <= 1'b1;
            s1_we_q       <= ~ram_we_b;
            s1_addr_q     <= cmd_addr;
            s1_fwd_q      <= s2_hit_cmd;
            s1_fwd_data_q <= ram_data_in;
            s2_valid_q    <= s1_valid_q;
            s2_we_q       <= s1_we_q;
            s2_addr_q     <= s1_addr_q;
            ram_data_oe   <= s1_rd;
            ram_data_out  <= s1_rd ? rd_data_d : '0;
        end
    end

`ifdef ZBT_RESP_STATS_EN
    logic [15:0] rd_count_q, wr_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else if (!ram_cen_b && s2_valid_q) begin
            if (s2_we_q) begin
                if (wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
            end else begin
                if (rd_count_q != 16'hFFFF) rd_count_q <= rd_count_q + 16'd1;
            end
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule

// File: tb/tb_zbt_responder.sv
module tb_zbt_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        ram_cen_b;
    logic        ram_we_b;
    logic [18:0] ram_address;
    logic [35:0] ram_data_in;
    logic [35:0] ram_data_out;
    logic        ram_data_oe;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    always #5 clk = ~clk;

    zbt_responder #(.ADDR_W(12), .DATA_W(36)) dut (
        .clk          (clk),
        .reset        (reset),
        .ram_cen_b    (ram_cen_b),
        .ram_we_b     (ram_we_b),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out),
        .ram_data_oe  (ram_data_oe),
        .rd_count     (rd_count),
        .wr_count     (wr_count)
    );

    int total = 0;
    int bad   = 0;

    // Reference: committed array plus the commands in flight (index 0 = newest).
    logic [35:0] ref_mem [4096];
    logic        bp_v  [2];
    logic        bp_we [2];
    logic [11:0] bp_a  [2];
    logic [35:0] bp_d  [2];
    logic [35:0] exp_q [$];
    int unsigned rd_model, wr_model;

    function automatic logic [35:0] rand36();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[35:0];
    endfunction

    function automatic logic [15:0] exp_cnt(input int unsigned n);
        logic [15:0] v;
        v = (n > 65535) ? 16'hFFFF : 16'(n);
`ifndef ZBT_RESP_STATS_EN
        v = 16'd0;
`endif
        return v;
    endfunction

    function automatic logic exp_oe();
        return bp_v[1] && !bp_we[1];
    endfunction

    // One clock: drive a command (or a stall), supply write data for a retiring write,
    // and keep the scoreboard in step with enabled edges.
    task automatic do_cycle(input bit en, input bit we, input logic [18:0] addr,
                            input logic [35:0] wd);
        logic [11:0] a;
        logic [35:0] e;
        a           = addr[11:0];
        reset       = 1'b0;
        ram_cen_b   = !en;
        ram_we_b    = !we;
        ram_address = addr;
        ram_data_in = (bp_v[1] && bp_we[1]) ? bp_d[1] : rand36();
        @(posedge clk);
        if (en) begin
            if (bp_v[1]) begin
                if (bp_we[1]) begin
                    ref_mem[bp_a[1]] = bp_d[1];
                    wr_model++;
                end else begin
                    rd_model++;
                    void'(exp_q.pop_front());
                end
            end
            if (!we) begin
                if (bp_v[0] && bp_we[0] && bp_a[0] == a) e = bp_d[0];
                else e = ref_mem[a];
                exp_q.push_back(e);
            end
            bp_v[1] = bp_v[0]; bp_we[1] = bp_we[0]; bp_a[1] = bp_a[0]; bp_d[1] = bp_d[0];
            bp_v[0] = 1'b1;    bp_we[0] = we;       bp_a[0] = a;       bp_d[0] = wd;
        end
        #1;
    endtask

    task automatic do_reset(input logic [35:0] bus);
        reset       = 1'b1;
        ram_cen_b   = 1'b0;
        ram_we_b    = 1'b1;
        ram_address = '0;
        ram_data_in = bus;
        @(posedge clk);
        bp_v[0] = 1'b0; bp_v[1] = 1'b0;
        bp_we[0] = 1'b0; bp_we[1] = 1'b0;
        exp_q.delete();
        rd_model = 0;
        wr_model = 0;
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(36'h0);
        do_reset(36'h0);
        total++; if (ram_data_oe !== 1'b0) begin bad++; $display("FAIL reset_oe: got %b want 0", ram_data_oe); end
        total++; if (ram_data_out !== 36'h0) begin bad++; $display("FAIL reset_out: got %h want 0", ram_data_out); end
        total++; if (rd_count !== 16'h0) begin bad++; $display("FAIL reset_rd: got %h want 0", rd_count); end
        total++; if (wr_count !== 16'h0) begin bad++; $display("FAIL reset_wr: got %h want 0", wr_count); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) do_cycle(1'b1, 1'b1, 19'(i), rand36());
        do_cycle(1'b1, 1'b0, 19'd0, '0);
        do_cycle(1'b1, 1'b0, 19'd0, '0);
        total++; if (ram_data_oe !== 1'b1 || ram_data_out !== exp_q[0]) begin
            bad++; $display("FAIL fill_read: got oe=%b %h want oe=1 %h", ram_data_oe, ram_data_out, exp_q[0]);
        end
    endtask

    task automatic test_write_idle_read();
        do_reset(36'h0);
        do_cycle(1'b1, 1'b1, 19'd5, 36'h123456789);
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b0, 19'd0, '0);
        do_cycle(1'b1, 1'b0, 19'd5, '0);
        do_cycle(1'b1, 1'b0, 19'd0, '0);
        total++; if (ram_data_oe !== 1'b1) begin bad++; $display("FAIL wir_oe: got %b want 1", ram_data_oe); end
        total++; if (ram_data_out !== 36'h123456789) begin
            bad++; $display("FAIL wir_data: got %h want 123456789", ram_data_out);
        end
        do_cycle(1'b1, 1'b0, 19'd0, '0);
        total++; if (wr_count !== exp_cnt(1)) begin bad++; $display("FAIL wir_wr_count: got %0d want %0d", wr_count, exp_cnt(1)); end
        total++; if (rd_count !== exp_cnt(1)) begin bad++; $display("FAIL wir_rd_count: got %0d want %0d", rd_count, exp_cnt(1)); end
    endtask

    task automatic test_back_to_back();
        do_reset(36'h0);
        do_cycle(1'b1, 1'b1, 19'd7, 36'hA_5A5A_0007);
        do_cycle(1'b1, 1'b0, 19'd7, '0);
        do_cycle(1'b1, 1'b0, 19'd7, '0);
        total++; if (ram_data_oe !== 1'b1 || ram_data_out !== 36'hA_5A5A_0007) begin
            bad++; $display("FAIL b2b_read1: got oe=%b %h want oe=1 a5a5a0007", ram_data_oe, ram_data_out);
        end
        do_cycle(1'b1, 1'b1, 19'd8, 36'hD_0000_0008);
        total++; if (ram_data_oe !== 1'b1 || ram_data_out !== 36'hA_5A5A_0007) begin
            bad++; $display("FAIL b2b_read2: got oe=%b %h want oe=1 a5a5a0007", ram_data_oe, ram_data_out);
        end
    endtask

    task automatic test_stall_hold();
        do_reset(36'h0);
        do_cycle(1'b1, 1'b0, 19'd7, '0);
        do_cycle(1'b1, 1'b1, 19'd8, 36'hD_0000_0018);
        for (int i = 0; i < 5; i++) begin
            total++; if (ram_data_oe !== 1'b1 || ram_data_out !== 36'hA_5A5A_0007) begin
                bad++; $display("FAIL stall_hold_%0d: got oe=%b %h want oe=1 a5a5a0007", i, ram_data_oe, ram_data_out);
            end
            if (i < 4) do_cycle(1'b0, 1'b0, 19'd0, '0);
        end
        do_cycle(1'b1, 1'b1, 19'd10, 36'hE_0000_0010);
        total++; if (ram_data_oe !== 1'b0) begin bad++; $display("FAIL stall_drop_oe: got %b want 0", ram_data_oe); end
    endtask

    task automatic test_alias();
        do_reset(36'h0);
        do_cycle(1'b1, 1'b1, 19'h01003, 36'hF_00F0_0F03);
        do_cycle(1'b1, 1'b0, 19'h00003, '0);
        do_cycle(1'b1, 1'b0, 19'h00000, '0);
        total++; if (ram_data_oe !== 1'b1 || ram_data_out !== 36'hF_00F0_0F03) begin
            bad++; $display("FAIL alias_fwd: got oe=%b %h want oe=1 f00f00f03", ram_data_oe, ram_data_out);
        end
        do_cycle(1'b1, 1'b0, 19'h45003, '0);
        do_cycle(1'b1, 1'b0, 19'h00000, '0);
        total++; if (ram_data_oe !== 1'b1 || ram_data_out !== 36'hF_00F0_0F03) begin
            bad++; $display("FAIL alias_array: got oe=%b %h want oe=1 f00f00f03", ram_data_oe, ram_data_out);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset(36'h0);
        do_cycle(1'b1, 1'b1, 19'd9, 36'h0_AAAA_5555);
        do_cycle(1'b1, 1'b0, 19'd0, '0);
        do_cycle(1'b1, 1'b0, 19'd0, '0);
        do_cycle(1'b1, 1'b1, 19'd9, 36'hB_BBBB_BBBB);
        do_cycle(1'b1, 1'b0, 19'd0, '0);
        do_reset(36'hB_BBBB_BBBB);
        total++; if (ram_data_oe !== 1'b0) begin bad++; $display("FAIL midrst_oe: got %b want 0", ram_data_oe); end
        total++; if (ram_data_out !== 36'h0) begin bad++; $display("FAIL midrst_out: got %h want 0", ram_data_out); end
        total++; if (rd_count !== 16'h0 || wr_count !== 16'h0) begin
            bad++; $display("FAIL midrst_counts: got rd=%0d wr=%0d want 0 0", rd_count, wr_count);
        end
        do_cycle(1'b1, 1'b0, 19'd9, '0);
        do_cycle(1'b1, 1'b0, 19'd0, '0);
        total++; if (ram_data_oe !== 1'b1 || ram_data_out !== 36'h0_AAAA_5555) begin
            bad++; $display("FAIL midrst_old: got oe=%b %h want oe=1 0aaaa5555", ram_data_oe, ram_data_out);
        end
    endtask

    task automatic test_mixed();
        logic [18:0] addr;
        do_reset(36'h0);
        for (int n = 0; n < 100; n++) begin
            if ($urandom_range(3) == 0) begin
                do_cycle(1'b0, 1'b0, 19'd0, '0);
                total++; if (ram_data_oe !== exp_oe()) begin
                    bad++; $display("FAIL mixed_stall_oe %0d: got %b want %b", n, ram_data_oe, exp_oe());
                end
            end
            addr = 19'($urandom) & 19'h7F00F;
            do_cycle(1'b1, 1'($urandom_range(1)), addr, rand36());
            total++; if (ram_data_oe !== exp_oe()) begin
                bad++; $display("FAIL mixed_oe %0d: got %b want %b", n, ram_data_oe, exp_oe());
            end
            if (exp_oe()) begin
                total++; if (ram_data_out !== exp_q[0]) begin
                    bad++; $display("FAIL mixed_data %0d: got %h want %h", n, ram_data_out, exp_q[0]);
                end
            end
        end
        total++; if (rd_count !== exp_cnt(rd_model)) begin
            bad++; $display("FAIL mixed_rd_count: got %0d want %0d", rd_count, exp_cnt(rd_model));
        end
        total++; if (wr_count !== exp_cnt(wr_model)) begin
            bad++; $display("FAIL mixed_wr_count: got %0d want %0d", wr_count, exp_cnt(wr_model));
        end
    endtask

    initial begin
        reset       = 1'b1;
        ram_cen_b   = 1'b1;
        ram_we_b    = 1'b1;
        ram_address = '0;
        ram_data_in = '0;
        rd_model    = 0;
        wr_model    = 0;
        test_reset();
        test_fill();
        test_write_idle_read();
        test_back_to_back();
        test_stall_hold();
        test_alias();
        test_reset_midflight();
        test_mixed();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/zbt_responder.md
# zbt_responder

Synthesizable responder for the ZBT SRAM pin interface: it plays the RAM side of the pipelined, two-cycle-latency protocol that our ZBT controller drives. It samples the chip-enable, write-enable and address, services reads and writes against an internal block-RAM-backed array, and drives or captures the data bus two enabled cycles after each command. It lets us run controller and frame-buffer logic in simulation, or on-chip with no external RAM, with bit-identical timing.

## Interface
Parameters:
- ADDR_W, 12, internal array depth is 2^ADDR_W words; only the low ADDR_W bits of ram_address are decoded.
- DATA_W, 36, data word width.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- ram_cen_b  input  1  active-low clock enable; high freezes the whole pipeline.
- ram_we_b  input  1  active-low write enable, sampled with the command.
- ram_address  input  19  command address.
- ram_data_in  input  DATA_W  data bus as seen by the responder (write data).
- ram_data_out  output  DATA_W  read data driven toward the controller.
- ram_data_oe  output  1  high while ram_data_out is valid and the responder owns the bus.
- rd_count  output  16  reads completed (statistics).
- wr_count  output  16  writes committed (statistics).

## Operation
- An enabled edge is a rising clk edge with ram_cen_b=0 and reset=0. Only enabled edges advance state.
- Command issue: at enabled edge E0, {we = ~ram_we_b, addr = ram_address[ADDR_W-1:0]} enters stage 1. Every enabled edge issues a command. There is no idle command; the controller idles by holding ram_cen_b high.
- Stage 1 to stage 2 on the next enabled edge (E1). Retire on E2.
- Write: at E2 the responder captures ram_data_in and commits it to addr.
- Read: after E1, stage 2 holds the read. ram_data_out is the word and ram_data_oe=1 during the cycle ending at E2. Outputs are registered and update only on enabled edges.
- Read semantics: a read returns the value written by the most recent write issued before it, even if that write has not yet committed. This requires forwarding from both in-flight write stages, which must be implemented. Forwarding is always by the ADDR_W-bit address compare.
- A write never drives the bus; ram_data_oe=0 whenever stage 2 holds a write or is empty.
- Stall (ram_cen_b=1): stages, ram_data_out, ram_data_oe and the counters all hold. The array is not written.
- Address bits [18:ADDR_W] are ignored, so addresses alias modulo 2^ADDR_W.

## Timing
- Reset (synchronous, overrides ram_cen_b):
  - Both stages are invalidated.
  - ram_data_oe=0, ram_data_out=0, rd_count=0, wr_count=0.
  - In-flight writes are dropped, but array contents are preserved.
  - Reset mid-operation means commands issued before the reset never complete.
- Read latency: exactly 2 enabled edges, command at E0 and data valid after E1 through E2.
- Write data latency: exactly 2 enabled edges, command at E0 and ram_data_in sampled at E2.
- Back-to-back commands at full rate. Read-after-write, write-after-read and read-after-read impose no bubbles.
- Same-address write at E0 followed by a read at E1: the read returns data sampled at E2, which is forwarded combinationally from ram_data_in onto the registered output path for the cycle ending at E3.
- Counters increment at the retiring edge (E2) and saturate at 16'hFFFF.

## Configuration
- ZBT_RESP_STATS_EN defined: rd_count and wr_count operate as specified.
- ZBT_RESP_STATS_EN undefined: rd_count and wr_count are tied to 0 and the counter logic is not synthesized. All other behaviour is unchanged.

## Test plan
- Write 36'h123456789 to addr 5 at E0, then idle (ram_cen_b=1) for 3 cycles, then read addr 5. Required: ram_data_oe=1 and ram_data_out=36'h123456789 exactly two enabled edges after the read issue; wr_count=1, rd_count=1.
- Back-to-back W(7,A), R(7), R(7), each with ram_cen_b=0. Required: both reads return A via forwarding, with no bubble and oe high for two consecutive cycles.
- Read issued, then ram_cen_b=1 for 4 cycles after E1. Required: ram_data_out and oe hold throughout the stall, then drop after the next enabled edge if no read follows.
- Write to addr 19'h01003 with ADDR_W=12, then read addr 3. Required: the written value is returned, confirming aliasing.
- Issue W(9,B), assert reset at the edge where the write would retire, then read 9. Required: the old value of addr 9 is returned, oe=0 and counters=0 immediately after reset.
- Build without ZBT_RESP_STATS_EN and run 100 mixed commands. Required: rd_count=wr_count=0 and data results identical to the stats build.
